// File: rtl/pin_capture_buffer.sv
// Probe-pin capture front end: synchronises the pins, waits for a masked trigger,
// then stores decimated samples in a block-RAM FIFO that the SPI stage drains.
module pin_capture_buffer #(
    parameter int DEPTH       = 256,
    parameter int CAPTURE_LEN = 256,
    parameter int DIV_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 pin_values,
    input  logic                       arm,
    input  logic [7:0]                 trig_mask,
    input  logic [7:0]                 trig_value,
    input  logic [DIV_W-1:0]           div,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [1:0]                 state,
    output logic                       overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [15:0]      LAST_IDX  = 16'(CAPTURE_LEN - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_sync1;
    logic [7:0]         r_sync2;

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_next;
    logic               r_empty;
    logic               r_full;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_overflow;

    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [15:0]        r_stored;

    logic               w_trig_hit;
    logic               w_div_hit;
    logic               w_last;
    logic               w_rd_accept;
    logic               w_strobe;
    logic               w_wr_en;
    logic               w_drop;

    // Two-flop synchroniser per pin; r_sync2 is the only view of the pins used below.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1[gi] <= 1'b0;
                    r_sync2[gi] <= 1'b0;
                end else begin
                    r_sync1[gi] <= pin_values[gi];
                    r_sync2[gi] <= r_sync1[gi];
                end
            end
        end
    endgenerate

    assign w_trig_hit  = ((r_sync2 ^ trig_value) & trig_mask) == 8'h00;
    assign w_div_hit   = (r_div_cnt == r_div_q);
    assign w_last      = (r_stored == LAST_IDX);
    assign w_rd_accept = rd_en && !r_empty && !arm;

    // The trigger cycle itself is sample 0; later strobes come from the divider.
    always_comb begin
        w_strobe = 1'b0;
        if (!arm) begin
            case (r_state)
                ST_ARMED:   w_strobe = w_trig_hit;
                ST_CAPTURE: w_strobe = w_div_hit;
                default:    w_strobe = 1'b0;
            endcase
        end
    end

    assign w_wr_en = w_strobe && (!r_full || w_rd_accept);
    assign w_drop  = w_strobe && r_full && !w_rd_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ST_ARMED;
        end else if (w_strobe && w_last) begin
            w_state_next = ST_DONE;
        end else if (r_state == ST_ARMED && w_trig_hit) begin
            w_state_next = ST_CAPTURE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q    <= '0;
            r_div_cnt  <= '0;
            r_stored   <= '0;
            r_overflow <= 1'b0;
        end else if (arm) begin
            r_div_cnt  <= '0;
            r_stored   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == ST_ARMED && w_trig_hit) begin
                r_div_q   <= div;
                r_div_cnt <= '0;
            end else if (r_state == ST_CAPTURE) begin
                r_div_cnt <= w_div_hit ? '0 : r_div_cnt + DIV_W'(1);
            end
            // Dropped samples still count so the capture window stays time-accurate.
            if (w_strobe) begin
                r_stored <= r_stored + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_level_next = r_level + LVL_W'(w_wr_en) - LVL_W'(w_rd_accept);

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            r_empty <= (w_level_next == '0);
            r_full  <= (w_level_next == LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_sync2;
        end
    end

    // Read-first: a pop from a full FIFO with a same-cycle write sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = r_empty;
    assign full     = r_full;
    assign level    = r_level;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pin_capture_buffer.sv
// Randomised bench for pin_capture_buffer, compared every cycle against a
// queue-based model of the capture rules.
module tb_pin_capture_buffer;

    localparam int DEPTH       = 8;
    localparam int CAPTURE_LEN = 12;
    localparam int DIV_W       = 8;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       pin_values = 8'h00;
    logic             arm = 1'b0;
    logic [7:0]       trig_mask = 8'h00;
    logic [7:0]       trig_value = 8'h00;
    logic [DIV_W-1:0] div = '0;
    logic             rd_en = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
    logic [1:0]       state;
    logic             overflow;

    always #5 clk = ~clk;

    pin_capture_buffer #(
        .DEPTH(DEPTH),
        .CAPTURE_LEN(CAPTURE_LEN),
        .DIV_W(DIV_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pin_values(pin_values),
        .arm(arm),
        .trig_mask(trig_mask),
        .trig_value(trig_value),
        .div(div),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .empty(empty),
        .full(full),
        .level(level),
        .state(state),
        .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_pins[$];
    int         m_state = 0;
    int         m_stored = 0;
    int         m_trig_cyc = 0;
    int         m_div_q = 0;
    logic       m_ovf = 1'b0;
    logic       m_rd_valid = 1'b0;
    logic [7:0] m_rd_data = 8'h00;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge of the capture rules, using the inputs currently applied.
    task automatic model_edge();
        logic [7:0] s;
        logic       accept;
        logic       sample;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_pins.delete();
            m_pins.push_back(8'h00);
            m_pins.push_back(8'h00);
            m_state    = 0;
            m_stored   = 0;
            m_ovf      = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = 8'h00;
            return;
        end
        s = m_pins.pop_front();
        m_pins.push_back(pin_values);
        if (arm) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_state    = 1;
            m_stored   = 0;
            m_rd_valid = 1'b0;
            return;
        end
        accept = rd_en && (m_q.size() > 0);
        sample = 1'b0;
        if (m_state == 1 && ((s & trig_mask) == (trig_value & trig_mask))) begin
            sample     = 1'b1;
            m_trig_cyc = cyc;
            m_div_q    = int'(div);
            m_state    = 2;
        end else if (m_state == 2 && ((cyc - m_trig_cyc) % (m_div_q + 1)) == 0) begin
            sample = 1'b1;
        end
        m_rd_valid = accept;
        if (accept) m_rd_data = m_q.pop_front();
        if (sample) begin
            if (m_q.size() < DEPTH) m_q.push_back(s);
            else m_ovf = 1'b1;
            m_stored++;
            if (m_stored == CAPTURE_LEN) m_state = 3;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_value("state",    32'(state),    32'(m_state));
        check_value("level",    32'(level),    32'(m_q.size()));
        check_value("empty",    32'(empty),    32'(m_q.size() == 0));
        check_value("full",     32'(full),     32'(m_q.size() == DEPTH));
        check_value("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check_value("rd_data",  32'(rd_data),  32'(m_rd_data));
        check_value("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        int mode;
        int rdp;
        int len;
        logic [7:0] ctr;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Masked trigger: 0x5F must never match, 0xA3 must.
        arm = 1'b1; trig_mask = 8'hF0; trig_value = 8'hA0; div = '0; pin_values = 8'h5F;
        step();
        arm = 1'b0;
        for (int i = 0; i < 10; i++) step();
        pin_values = 8'hA3;
        for (int i = 0; i < 6; i++) step();
        rd_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        rd_en = 1'b0;

        // Mid-capture reset held for two cycles.
        arm = 1'b1; trig_mask = 8'h00;
        step();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        for (int ep = 0; ep < 70; ep++) begin
            mode = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: rdp = 0;
                1: rdp = 25;
                2: rdp = 60;
                default: rdp = 100;
            endcase
            trig_mask  = (mode == 0) ? 8'h00 : ((mode == 3) ? 8'hF0 : 8'($urandom));
            trig_value = 8'($urandom);
            ctr = 8'($urandom);
            div = DIV_W'($urandom_range(0, 3));
            rd_en = ($urandom_range(0, 1) == 1);
            arm = 1'b1;
            step();
            arm = 1'b0;
            len = $urandom_range(20, 70);
            for (int i = 0; i < len; i++) begin
                ctr = ctr + 8'd1;
                pin_values = (mode == 1) ? ctr : 8'($urandom);
                div   = DIV_W'($urandom_range(0, 3));
                rd_en = ($urandom_range(0, 99) < rdp);
                arm   = ($urandom_range(0, 99) == 0);
                rst   = ($urandom_range(0, 199) == 0);
                step();
            end
            arm = 1'b0;
            rst = 1'b0;
            rd_en = 1'b1;
            for (int i = 0; i < 10; i++) step();
            rd_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
